// File: rtl/wb_stage_param.sv
// Write-back stage: registers the MEM/WB payload, picks the result source,
// extracts sub-word loads and drives the register-file write port, trace and retire count.
module wb_stage_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic              in_wr_en,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [1:0]        in_src_sel,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_aux_data,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_byte_off,
    output logic              out_valid,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [31:0]       debug_wb_pc,
    output logic [31:0]       debug_wb_inst,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;
    localparam logic [2:0] LD_LB    = 3'd1;
    localparam logic [2:0] LD_LBU   = 3'd2;
    localparam logic [2:0] LD_LH    = 3'd3;
    localparam logic [2:0] LD_LHU   = 3'd4;

    logic              r_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [1:0]        r_src_sel;
    logic [DATA_W-1:0] r_alu_data;
    logic [31:0]       r_mem_word;
    logic [DATA_W-1:0] r_aux_data;
    logic [2:0]        r_load_type;
    logic [1:0]        r_byte_off;
    logic [CNT_W-1:0]  r_cnt;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_link;

    // Stage register: flush beats stall; only the low load word is ever consumed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_src_sel   <= '0;
            r_alu_data  <= '0;
            r_mem_word  <= '0;
            r_aux_data  <= '0;
            r_load_type <= '0;
            r_byte_off  <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (!stall) begin
            r_valid     <= in_valid;
            r_pc        <= in_pc;
            r_inst      <= in_inst;
            r_wr_en     <= in_wr_en;
            r_wr_addr   <= in_wr_addr;
            r_src_sel   <= in_src_sel;
            r_alu_data  <= in_alu_data;
            r_mem_word  <= in_mem_data[31:0];
            r_aux_data  <= in_aux_data;
            r_load_type <= in_load_type;
            r_byte_off  <= in_byte_off;
        end
    end

    // An instruction retires when it leaves the stage, regardless of flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_valid && !stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_byte = r_mem_word[7:0];
        case (r_byte_off)
            2'd0:    w_byte = r_mem_word[7:0];
            2'd1:    w_byte = r_mem_word[15:8];
            2'd2:    w_byte = r_mem_word[23:16];
            default: w_byte = r_mem_word[31:24];
        endcase
        w_half = r_byte_off[1] ? r_mem_word[31:16] : r_mem_word[15:0];
    end

    always_comb begin
        w_load = DATA_W'(r_mem_word);
        case (r_load_type)
            LD_LB:   w_load = DATA_W'($signed(w_byte));
            LD_LBU:  w_load = DATA_W'(w_byte);
            LD_LH:   w_load = DATA_W'($signed(w_half));
            LD_LHU:  w_load = DATA_W'(w_half);
            default: w_load = DATA_W'(r_mem_word);
        endcase
    end

    assign w_link = DATA_W'(r_pc + 32'd8);

    always_comb begin
        rf_wdata = r_aux_data;
        case (r_src_sel)
            SRC_ALU:  rf_wdata = r_alu_data;
            SRC_MEM:  rf_wdata = w_load;
            SRC_LINK: rf_wdata = w_link;
            default:  rf_wdata = r_aux_data;
        endcase
    end

    assign out_valid     = r_valid;
    assign rf_we         = r_valid & r_wr_en & (r_wr_addr != '0);
    assign rf_waddr      = r_wr_addr;
    assign debug_wb_pc   = r_valid ? r_pc : 32'd0;
    assign debug_wb_inst = r_valid ? r_inst : 32'd0;
    assign retire_cnt    = r_cnt;

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed bench for wb_stage_param; a second instance with a 4-bit counter covers wrap-around.
module tb_wb_stage_param;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_wr_en;
    logic [4:0]  in_wr_addr;
    logic [1:0]  in_src_sel;
    logic [31:0] in_alu_data;
    logic [31:0] in_mem_data;
    logic [31:0] in_aux_data;
    logic [2:0]  in_load_type;
    logic [1:0]  in_byte_off;

    logic        out_valid, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc, debug_wb_inst, retire_cnt;

    logic        out_valid4, rf_we4;
    logic [4:0]  rf_waddr4;
    logic [31:0] rf_wdata4, debug_wb_pc4, debug_wb_inst4;
    logic [3:0]  retire_cnt4;

    int total = 0;
    int bad   = 0;

    wb_stage_param dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_src_sel(in_src_sel),
        .in_alu_data(in_alu_data), .in_mem_data(in_mem_data), .in_aux_data(in_aux_data),
        .in_load_type(in_load_type), .in_byte_off(in_byte_off),
        .out_valid(out_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_inst(debug_wb_inst), .retire_cnt(retire_cnt)
    );

    wb_stage_param #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_src_sel(in_src_sel),
        .in_alu_data(in_alu_data), .in_mem_data(in_mem_data), .in_aux_data(in_aux_data),
        .in_load_type(in_load_type), .in_byte_off(in_byte_off),
        .out_valid(out_valid4), .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .debug_wb_pc(debug_wb_pc4), .debug_wb_inst(debug_wb_inst4), .retire_cnt(retire_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 0; in_pc = 0; in_inst = 0;
        in_wr_en = 0; in_wr_addr = 0; in_src_sel = 0; in_alu_data = 0;
        in_mem_data = 0; in_aux_data = 0; in_load_type = 0; in_byte_off = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        #2 rstn = 0;
        #3 rstn = 1;
        step();
    endtask

    task automatic test_reset();
        rstn = 0;
        idle_inputs();
        #12 rstn = 1;
        step();
        in_valid = 1; in_pc = 32'h0000_1000; in_inst = 32'h8C88_0000; in_wr_en = 1;
        in_wr_addr = 5'd8; in_src_sel = 2'd1; in_mem_data = 32'hDEAD_BEEF; in_load_type = 3'd0;
        step();
        total++;
        if (out_valid !== 1'b1 || rf_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL reset_pre: valid=%b wdata=%h want 1 deadbeef", out_valid, rf_wdata);
        end
        step();
        #2 rstn = 0;
        #1;
        total++;
        if (out_valid !== 0 || rf_we !== 0 || rf_waddr !== 0 || rf_wdata !== 0 ||
            debug_wb_pc !== 0 || debug_wb_inst !== 0 || retire_cnt !== 0 || out_valid4 !== 0) begin
            bad++; $display("FAIL reset_async: v=%b we=%b a=%h d=%h pc=%h in=%h cnt=%0d want all 0",
                            out_valid, rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_inst, retire_cnt);
        end
        idle_inputs();
        #3 rstn = 1;
        step();
        total++;
        if (retire_cnt !== 0 || out_valid !== 0) begin
            bad++; $display("FAIL reset_release: cnt=%0d valid=%b want 0 0", retire_cnt, out_valid);
        end
    endtask

    task automatic test_alu();
        apply_reset();
        in_valid = 1; in_wr_en = 1; in_wr_addr = 5'd8; in_src_sel = 2'd0;
        in_alu_data = 32'h1234_5678; in_pc = 32'h0000_2000; in_inst = 32'h0109_4020;
        step();
        total++;
        if (rf_we !== 1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1234_5678 || retire_cnt !== 0) begin
            bad++; $display("FAIL alu_write: we=%b a=%0d d=%h cnt=%0d want 1 8 12345678 0",
                            rf_we, rf_waddr, rf_wdata, retire_cnt);
        end
        total++;
        if (debug_wb_pc !== 32'h0000_2000 || debug_wb_inst !== 32'h0109_4020) begin
            bad++; $display("FAIL alu_debug: pc=%h inst=%h want 00002000 01094020", debug_wb_pc, debug_wb_inst);
        end
        in_valid = 0;
        step();
        total++;
        if (retire_cnt !== 1 || out_valid !== 0 || debug_wb_pc !== 0 || rf_we !== 0) begin
            bad++; $display("FAIL alu_retire: cnt=%0d valid=%b pc=%h we=%b want 1 0 0 0",
                            retire_cnt, out_valid, debug_wb_pc, rf_we);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [9];
        logic [1:0]  off [9];
        logic [31:0] exp [9];
        lt[0] = 3'd1; off[0] = 2'd3; exp[0] = 32'hFFFF_FF80;
        lt[1] = 3'd2; off[1] = 2'd3; exp[1] = 32'h0000_0080;
        lt[2] = 3'd3; off[2] = 2'd2; exp[2] = 32'hFFFF_80FF;
        lt[3] = 3'd4; off[3] = 2'd1; exp[3] = 32'h0000_7F01;
        lt[4] = 3'd0; off[4] = 2'd0; exp[4] = 32'h80FF_7F01;
        lt[5] = 3'd1; off[5] = 2'd1; exp[5] = 32'h0000_007F;
        lt[6] = 3'd1; off[6] = 2'd2; exp[6] = 32'hFFFF_FFFF;
        lt[7] = 3'd3; off[7] = 2'd1; exp[7] = 32'h0000_7F01;
        lt[8] = 3'd6; off[8] = 2'd3; exp[8] = 32'h80FF_7F01;
        apply_reset();
        in_valid = 1; in_wr_en = 1; in_wr_addr = 5'd4; in_src_sel = 2'd1;
        in_mem_data = 32'h80FF_7F01; in_alu_data = 32'h5555_5555;
        for (int i = 0; i < 9; i++) begin
            in_load_type = lt[i]; in_byte_off = off[i];
            step();
            total++;
            if (rf_wdata !== exp[i]) begin
                bad++; $display("FAIL load_%0d (type=%0d off=%0d): got %h want %h",
                                i, lt[i], off[i], rf_wdata, exp[i]);
            end
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_link_zero();
        apply_reset();
        in_valid = 1; in_wr_en = 1; in_wr_addr = 5'd31; in_src_sel = 2'd2; in_pc = 32'hBFC0_0100;
        in_aux_data = 32'hCAFE_0000;
        step();
        total++;
        if (rf_wdata !== 32'hBFC0_0108 || rf_we !== 1 || rf_waddr !== 5'd31) begin
            bad++; $display("FAIL link: d=%h we=%b a=%0d want bfc00108 1 31", rf_wdata, rf_we, rf_waddr);
        end
        in_wr_addr = 5'd0;
        step();
        total++;
        if (rf_we !== 0 || out_valid !== 1 || rf_waddr !== 0) begin
            bad++; $display("FAIL zero_reg: we=%b valid=%b a=%0d want 0 1 0", rf_we, out_valid, rf_waddr);
        end
        in_wr_addr = 5'd2; in_pc = 32'hFFFF_FFFC;
        step();
        total++;
        if (rf_wdata !== 32'h0000_0004) begin
            bad++; $display("FAIL link_wrap: d=%h want 00000004", rf_wdata);
        end
        in_src_sel = 2'd3;
        step();
        total++;
        if (rf_wdata !== 32'hCAFE_0000) begin
            bad++; $display("FAIL aux: d=%h want cafe0000", rf_wdata);
        end
        in_wr_en = 0;
        step();
        total++;
        if (rf_we !== 0 || retire_cnt !== 4) begin
            bad++; $display("FAIL wr_en_off: we=%b cnt=%0d want 0 4", rf_we, retire_cnt);
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_stall_flush();
        apply_reset();
        in_valid = 1; in_wr_en = 1; in_wr_addr = 5'd5; in_src_sel = 2'd0;
        in_alu_data = 32'hA5A5_0001; in_pc = 32'h0000_0100; in_inst = 32'h0000_1234;
        step();
        stall = 1;
        in_wr_addr = 5'd9; in_alu_data = 32'h0F0F_0F0F; in_pc = 32'h0000_0200; in_inst = 32'h0000_5678;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (rf_wdata !== 32'hA5A5_0001 || rf_waddr !== 5'd5 || debug_wb_pc !== 32'h0000_0100 ||
                out_valid !== 1 || retire_cnt !== 0) begin
                bad++; $display("FAIL stall_hold_%0d: d=%h a=%0d pc=%h v=%b cnt=%0d want a5a50001 5 100 1 0",
                                i, rf_wdata, rf_waddr, debug_wb_pc, out_valid, retire_cnt);
            end
        end
        stall = 0;
        step();
        total++;
        if (retire_cnt !== 1 || rf_wdata !== 32'h0F0F_0F0F || rf_waddr !== 5'd9) begin
            bad++; $display("FAIL stall_release: cnt=%0d d=%h a=%0d want 1 0f0f0f0f 9",
                            retire_cnt, rf_wdata, rf_waddr);
        end
        flush = 1; stall = 1;
        step();
        total++;
        if (out_valid !== 0 || rf_we !== 0 || debug_wb_pc !== 0 || retire_cnt !== 1) begin
            bad++; $display("FAIL flush_stall: v=%b we=%b pc=%h cnt=%0d want 0 0 0 1",
                            out_valid, rf_we, debug_wb_pc, retire_cnt);
        end
        flush = 0; stall = 0;
        step();
        flush = 1;
        step();
        total++;
        if (out_valid !== 0 || retire_cnt !== 2) begin
            bad++; $display("FAIL flush_retire: v=%b cnt=%0d want 0 2", out_valid, retire_cnt);
        end
        flush = 0; in_valid = 0;
        step();
    endtask

    task automatic test_wrap();
        apply_reset();
        in_valid = 1; in_wr_en = 1; in_wr_addr = 5'd3; in_alu_data = 32'h1;
        for (int i = 0; i < 17; i++) step();
        in_valid = 0;
        step();
        total++;
        if (retire_cnt4 !== 4'd1 || retire_cnt !== 32'd17) begin
            bad++; $display("FAIL cnt_wrap: cnt4=%0d cnt32=%0d want 1 17", retire_cnt4, retire_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_link_zero();
        test_stall_flush();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage_param.md
Name: wb_stage_param

Overview:
Parametrised write-back stage for the cqu_mips five-stage pipeline.
- Registers the full MEM/WB payload, including address and enable.
- Adds valid/stall/flush control.
- Selects among four result sources.
- Performs sub-word load extraction with sign or zero extension.
- Drives the register-file write port, debug trace outputs and a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width; must be >= 32.
ADDR_W, 5, register-file address width.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
stall  input  1  hold stage register contents
flush  input  1  invalidate instruction entering the stage
in_valid  input  1  incoming instruction valid
in_pc  input  32  PC of incoming instruction
in_inst  input  32  instruction word
in_wr_en  input  1  instruction writes a register
in_wr_addr  input  ADDR_W  destination register
in_src_sel  input  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 AUX
in_alu_data  input  DATA_W  ALU result
in_mem_data  input  DATA_W  raw aligned load word
in_aux_data  input  DATA_W  HI/LO/CP0 read data
in_load_type  input  3  load format: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
in_byte_off  input  2  address bits [1:0] of the load
out_valid  output  1  stage holds a valid instruction
rf_we  output  1  register-file write enable
rf_waddr  output  ADDR_W  register-file write address
rf_wdata  output  DATA_W  register-file write data
debug_wb_pc  output  32  PC of instruction in the stage
debug_wb_inst  output  32  instruction word in the stage
retire_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset is asynchronous on the falling edge of rstn. While rstn is low, all stage registers clear to 0. As a result:
  - out_valid, rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_inst and retire_cnt read 0.
  - Deasserting reset mid-operation resumes with an empty stage.
- Stage register update at each posedge clk:
  - If flush: valid <= 0, payload don't-care. Flush has priority over stall.
  - Else if stall: all fields hold.
  - Else: capture every in_* field; valid <= in_valid.
- Latency: one cycle from input capture to rf_* outputs. rf_* are combinational from registered fields only; no input reaches an output combinationally.
- Write enable: rf_we = valid & wr_en & (wr_addr != 0). Writes to $0 are suppressed. rf_waddr always reflects the registered address.
- LINK source value is zero-extend(pc + 8), computed from the registered pc; 32-bit add with wrap.
- Load extraction applies when src_sel = 1. It uses the low 32 bits of mem_data, little-endian (offset 0 = bits 7:0).
  - LB / LBU: byte at offset, sign- / zero-extended to DATA_W.
  - LH / LHU: halfword at offset[1]; offset[0] is ignored; sign- / zero-extended.
  - LW, and load_type codes 5–7: low 32 bits, zero-extended to DATA_W.
- Sources ALU and AUX pass through unchanged.
- Debug outputs: debug_wb_pc and debug_wb_inst show the registered pc/inst while valid, and 0 when not valid.
- Retire counter: retire_cnt increments by 1 on each posedge where valid=1 and stall=0.
  - A stalled instruction is counted once, when it leaves the stage.
  - Flush does not cancel the instruction currently in the stage; flush acts on the incoming one only.
  - The counter wraps modulo 2^CNT_W.
- Simultaneous flush and stall: flush wins and the stage becomes empty. The current valid instruction is not counted that cycle, because stall=1.

Test Plan:
1. Reset mid-stream: valid LW in flight, pull rstn low between edges -> all outputs 0 immediately; retire_cnt=0 after release.
2. ALU write: in_valid=1, wr_en=1, addr=8, src=0, alu=0x12345678 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x12345678; retire_cnt=1 one edge later.
3. Load formats with mem=0x80FF7F01:
   - LB off=3 -> 0xFFFFFF80
   - LBU off=3 -> 0x00000080
   - LH off=2 -> 0xFFFF80FF
   - LHU off=1 -> 0x00007F01
   - LW -> 0x80FF7F01
4. Link and $0: src=2, pc=0xBFC00100, addr=31 -> rf_wdata=0xBFC00108, rf_we=1. Repeat with addr=0 -> rf_we=0 with valid=1.
5. Stall/flush: stall for 3 cycles with valid instruction in stage -> outputs constant, retire_cnt unchanged until release, then +1 exactly once. Assert flush and stall together -> out_valid=0 next cycle.
6. Counter wrap with CNT_W=4: 17 unstalled valid instructions -> retire_cnt=1.
